// File: rtl/scr_arb_pkg.sv
// Shared definitions for the screen/work RAM arbiter: grant-state encoding
// and the default RAM address width.
package scr_arb_pkg;

   localparam int SCR_AW = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DMA  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/scr_dma_arb.sv
// Arbiter between the video DMA reader and the sub-CPU work-RAM port onto one
// synchronous RAM port; returns read data and drives both requesters' stalls.
module scr_dma_arb
   import scr_arb_pkg::*;
#(
   parameter int DMA_BURST = 8,
   parameter int AW        = SCR_AW
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          cpu_en,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_ab,
   input  logic [7:0]    cpu_dout,
   output logic [7:0]    cpu_din,
   output logic          cpu_wait,
   input  logic          dma_en,
   input  logic [AW-2:0] dma_addr,
   output logic          dma_wait,
   output logic          dma_valid,
   output logic [7:0]    dma_data,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_wr,
   input  logic [7:0]    ram_q
);

   localparam logic [7:0] BURST_MAX = 8'(DMA_BURST);

   arb_state_t    r_last;
   logic          r_served;
   logic [AW-1:0] r_cpu_ab_q;
   logic [7:0]    r_burst_cnt;
   logic          r_cpu_rd;
   logic [7:0]    r_cpu_din;
   logic [AW-1:0] r_ram_addr_q;

   logic          w_same_access;
   logic          w_cpu_pend;
   logic          w_burst_full;
   logic          w_cpu_grant;
   logic          w_dma_grant;

   // Grant selection; an address change re-opens the CPU access immediately.
   always_comb begin
      w_same_access = r_served & (cpu_ab == r_cpu_ab_q);
      w_cpu_pend    = cpu_en & ~w_same_access;
      w_burst_full  = (r_burst_cnt == BURST_MAX);
      w_cpu_grant   = 1'b0;
      w_dma_grant   = 1'b0;
      if (!reset_n) begin
         w_cpu_grant = 1'b0;
         w_dma_grant = 1'b0;
      end else if (w_cpu_pend && dma_en) begin
         w_cpu_grant = w_burst_full;
         w_dma_grant = ~w_burst_full;
      end else begin
         w_cpu_grant = w_cpu_pend;
         w_dma_grant = dma_en;
      end
   end

   // RAM port mux; the address parks on its last value when nobody is granted.
   always_comb begin
      ram_addr = r_ram_addr_q;
      ram_wr   = 1'b0;
      ram_din  = 8'h00;
      if (w_cpu_grant) begin
         ram_addr = cpu_ab;
         ram_wr   = cpu_wr;
         ram_din  = cpu_dout;
      end else if (w_dma_grant) begin
         ram_addr = {1'b0, dma_addr};
      end else begin
         ram_addr = r_ram_addr_q;
      end
   end

   assign cpu_wait  = w_cpu_pend;
   assign dma_wait  = dma_en & ~w_dma_grant;
   assign dma_valid = (r_last == ST_DMA);
   assign dma_data  = dma_valid ? ram_q : 8'h00;
   assign cpu_din   = r_cpu_din;

   // Grant of the previous cycle.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= ST_IDLE;
      end else begin
         case ({w_cpu_grant, w_dma_grant})
            2'b10:   r_last <= ST_CPU;
            2'b01:   r_last <= ST_DMA;
            default: r_last <= ST_IDLE;
         endcase
      end
   end

   // Served flag makes a held chip select execute exactly once.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_served   <= 1'b0;
         r_cpu_ab_q <= '0;
         r_cpu_rd   <= 1'b0;
      end else if (w_cpu_grant) begin
         r_served   <= 1'b1;
         r_cpu_ab_q <= cpu_ab;
         r_cpu_rd   <= ~cpu_wr;
      end else if (!cpu_en || (cpu_ab != r_cpu_ab_q)) begin
         r_served   <= 1'b0;
      end else begin
         r_served   <= r_served;
      end
   end

   // DMA burst counter bounding CPU starvation.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_burst_cnt <= 8'd0;
      end else if (w_cpu_grant || !w_cpu_pend) begin
         r_burst_cnt <= 8'd0;
      end else if (w_dma_grant && !w_burst_full) begin
         r_burst_cnt <= r_burst_cnt + 8'd1;
      end else begin
         r_burst_cnt <= r_burst_cnt;
      end
   end

   // CPU read data capture and parked RAM address.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_cpu_din    <= 8'h00;
         r_ram_addr_q <= '0;
      end else begin
         r_ram_addr_q <= ram_addr;
         if (r_last == ST_CPU && r_cpu_rd) begin
            r_cpu_din <= ram_q;
         end else begin
            r_cpu_din <= r_cpu_din;
         end
      end
   end

endmodule

// File: tb/tb_scr_dma_arb.sv
// Scoreboard bench for scr_dma_arb: directed stimulus pushes expected read
// data; a negedge monitor pops and compares whenever the DUT returns data.
module tb_scr_dma_arb;
   import scr_arb_pkg::*;

   localparam int AW = SCR_AW;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          cpu_en, cpu_wr;
   logic [AW-1:0] cpu_ab;
   logic [7:0]    cpu_dout, cpu_din;
   logic          cpu_wait;
   logic          dma_en;
   logic [AW-2:0] dma_addr;
   logic          dma_wait, dma_valid;
   logic [7:0]    dma_data;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din, ram_q;
   logic          ram_wr;

   logic [7:0]    mem [0:(1<<AW)-1];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [7:0]    pl_data;

   logic [7:0]    dma_q [$];
   logic [7:0]    cpu_q [$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            wr_count = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic          prev_cpu_wait = 1'b0;
   logic          din_due = 1'b0;

   always #5 clk_sys = ~clk_sys;

   scr_dma_arb #(.DMA_BURST(8), .AW(AW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_ab(cpu_ab), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .cpu_wait(cpu_wait),
      .dma_en(dma_en), .dma_addr(dma_addr), .dma_wait(dma_wait),
      .dma_valid(dma_valid), .dma_data(dma_data),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr), .ram_q(ram_q)
   );

   // Synchronous single-port RAM model with a bench preload path.
   always @(posedge clk_sys) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ram_wr) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      step();
      pl_en   = 1'b0;
   endtask

   // Monitor: pops expected data whenever the DUT presents a response.
   always @(negedge clk_sys) begin
      logic [7:0] e;
      if (ram_wr) begin
         wr_count++;
         last_wr_addr = ram_addr;
      end
      if (dma_valid) begin
         if (dma_q.size() == 0) begin
            n_checks++;
            $display("FAIL dma_unexpected: got data %0h, expected no beat", dma_data);
         end else begin
            e = dma_q.pop_front();
            chk("dma_data", 32'(dma_data), 32'(e));
         end
      end
      if (din_due) begin
         if (cpu_q.size() == 0) begin
            n_checks++;
            $display("FAIL cpu_unexpected: got read %0h, expected no read", cpu_din);
         end else begin
            e = cpu_q.pop_front();
            chk("cpu_din", 32'(cpu_din), 32'(e));
         end
      end
      din_due       = cpu_en & ~cpu_wr & ~cpu_wait & prev_cpu_wait;
      prev_cpu_wait = cpu_wait;
   end

   initial begin
      int          wr0, nwait, ndwait, nbeats;
      logic [12:0] a;
      reset_n  = 1'b0;
      cpu_en   = 1'b0;
      cpu_wr   = 1'b0;
      cpu_ab   = '0;
      cpu_dout = 8'h00;
      dma_en   = 1'b0;
      dma_addr = '0;
      pl_en    = 1'b0;
      pl_addr  = '0;
      pl_data  = 8'h00;
      step();
      chk("rst_dma_valid", 32'(dma_valid), 32'd0);
      chk("rst_ram_wr", 32'(ram_wr), 32'd0);
      chk("rst_cpu_din", 32'(cpu_din), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);

      for (int i = 0; i < 4; i++) preload(14'(i), 8'h10 + 8'(i));
      preload(14'h2005, 8'h5A);
      preload(14'h0040, 8'hC3);
      preload(14'h0010, 8'h77);
      preload(14'h0011, 8'h88);
      for (int i = 0; i < 20; i++) preload(14'h0200 + 14'(i), 8'h40 + 8'(i));
      for (int i = 0; i < 6; i++) preload(14'h0300 + 14'(i), 8'h60 + 8'(i));
      reset_n = 1'b1;

      // DMA only
      for (int i = 0; i < 4; i++) begin
         dma_en   = 1'b1;
         dma_addr = 13'(i);
         #2;
         chk("dma_only_wait", 32'(dma_wait), 32'd0);
         dma_q.push_back(8'h10 + 8'(i));
         step();
      end
      dma_en = 1'b0;
      step();
      step();
      chk("dma_only_drain", 32'(dma_q.size()), 32'd0);

      // CPU read on an idle bus
      wr0    = wr_count;
      nwait  = 0;
      cpu_en = 1'b1;
      cpu_wr = 1'b0;
      cpu_ab = 14'h2005;
      cpu_q.push_back(8'h5A);
      for (int c = 0; c < 4; c++) begin
         #2;
         if (cpu_wait) nwait++;
         step();
      end
      chk("cpu_rd_wait_cycles", 32'(nwait), 32'd1);
      chk("cpu_rd_hold", 32'(cpu_din), 32'h5A);
      chk("cpu_rd_no_write", 32'(wr_count - wr0), 32'd0);
      cpu_en = 1'b0;
      step();

      // CPU write held for five cycles, then DMA readback
      wr0      = wr_count;
      cpu_en   = 1'b1;
      cpu_wr   = 1'b1;
      cpu_ab   = 14'h0100;
      cpu_dout = 8'hA5;
      for (int c = 0; c < 5; c++) step();
      cpu_en = 1'b0;
      cpu_wr = 1'b0;
      step();
      chk("cpu_wr_pulses", 32'(wr_count - wr0), 32'd1);
      chk("cpu_wr_addr", 32'(last_wr_addr), 32'h0100);
      dma_en   = 1'b1;
      dma_addr = 13'h0100;
      dma_q.push_back(8'hA5);
      step();
      dma_en = 1'b0;
      step();
      step();

      // Contention: continuous DMA, CPU read raised mid-stream
      a      = 13'h0200;
      nwait  = 0;
      ndwait = 0;
      nbeats = 0;
      dma_en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         dma_addr = a;
         if (c == 3) begin
            cpu_en = 1'b1;
            cpu_wr = 1'b0;
            cpu_ab = 14'h0040;
            cpu_q.push_back(8'hC3);
         end
         #2;
         if (cpu_wait) nwait++;
         if (dma_wait) ndwait++;
         else begin
            dma_q.push_back(8'h40 + 8'(a - 13'h0200));
            if (cpu_wait) nbeats++;
            a++;
         end
         step();
      end
      dma_en = 1'b0;
      cpu_en = 1'b0;
      step();
      step();
      chk("cont_cpu_wait_cycles", 32'(nwait), 32'd9);
      chk("cont_dma_wait_cycles", 32'(ndwait), 32'd1);
      chk("cont_burst_beats", 32'(nbeats), 32'd8);

      // Back-to-back CPU reads with cpu_en held
      nwait  = 0;
      cpu_en = 1'b1;
      cpu_wr = 1'b0;
      cpu_ab = 14'h0010;
      cpu_q.push_back(8'h77);
      for (int c = 0; c < 6; c++) begin
         if (c == 3) begin
            cpu_ab = 14'h0011;
            cpu_q.push_back(8'h88);
         end
         #2;
         if (cpu_wait) nwait++;
         step();
      end
      cpu_en = 1'b0;
      step();
      chk("b2b_wait_cycles", 32'(nwait), 32'd2);
      chk("b2b_hold", 32'(cpu_din), 32'h88);

      // Asynchronous reset in the middle of a DMA burst
      dma_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         dma_addr = 13'h0300 + 13'(c);
         #2;
         chk("rst_burst_wait", 32'(dma_wait), 32'd0);
         if (c < 2) dma_q.push_back(8'h60 + 8'(c));
         step();
      end
      dma_addr = 13'h0303;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_dma_valid", 32'(dma_valid), 32'd0);
      chk("arst_dma_data", 32'(dma_data), 32'd0);
      chk("arst_ram_wr", 32'(ram_wr), 32'd0);
      chk("arst_cpu_din", 32'(cpu_din), 32'd0);
      chk("arst_ram_addr", 32'(ram_addr), 32'd0);
      @(posedge clk_sys);
      #1;
      reset_n  = 1'b1;
      dma_addr = 13'h0305;
      #1;
      chk("post_rst_first_grant", 32'(dma_wait), 32'd0);
      dma_q.push_back(8'h65);
      step();
      dma_en = 1'b0;
      step();
      step();

      chk("final_dma_queue", 32'(dma_q.size()), 32'd0);
      chk("final_cpu_queue", 32'(cpu_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
